// File: rtl/ext_pkg.sv
// Shared encodings and helpers for the immediate-extend pipeline.
package ext_pkg;

  localparam int unsigned EXT_OP_W = 3;

  localparam logic [EXT_OP_W-1:0] EXT_ZERO  = 3'b000;
  localparam logic [EXT_OP_W-1:0] EXT_SIGN  = 3'b001;
  localparam logic [EXT_OP_W-1:0] EXT_LUI   = 3'b010;
  localparam logic [EXT_OP_W-1:0] EXT_BROFF = 3'b011;

  // Every encoding above the last defined mode is undefined.
  function automatic logic is_illegal_op(input logic [EXT_OP_W-1:0] op);
    return (op > EXT_BROFF);
  endfunction

endpackage

// File: rtl/ext_pipe_core.sv
// Combinational immediate extender: maps imm/ext_op to the extended word and an illegal flag.
module ext_pipe_core
  import ext_pkg::*;
#(
  parameter int unsigned IMM_W  = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic [IMM_W-1:0]    imm,
  input  logic [EXT_OP_W-1:0] ext_op,
  output logic [DATA_W-1:0]   ext_out,
  output logic                illegal_op
);

  logic [DATA_W-1:0] sext;

  assign sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

  always_comb begin
    ext_out    = '0;
    illegal_op = is_illegal_op(ext_op);
    case (ext_op)
      EXT_ZERO:  ext_out = {{(DATA_W-IMM_W){1'b0}}, imm};
      EXT_SIGN:  ext_out = sext;
      EXT_LUI:   ext_out[DATA_W-1 -: IMM_W] = imm;
      // Top two bits of the sign-extended value fall off the word.
      EXT_BROFF: ext_out = sext << 2;
      default:   ext_out = {DATA_W{imm[IMM_W-1]}};
    endcase
  end

endmodule

// File: rtl/ext_pipe.sv
// Registered immediate-extend unit: one main output register plus a skid register,
// valid/ready on both sides, and a saturating count of accepted illegal ops.
module ext_pipe
  import ext_pkg::*;
#(
  parameter int unsigned IMM_W     = 16,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IMM_W-1:0]     imm,
  input  logic [EXT_OP_W-1:0]  ext_op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    ext_out,
  output logic                 illegal_op,
  output logic [ILL_CNT_W-1:0] ill_cnt
);

  logic [DATA_W-1:0]    core_out;
  logic                 core_ill;

  logic                 main_valid_q, main_valid_d;
  logic [DATA_W-1:0]    main_data_q, main_data_d;
  logic                 main_ill_q, main_ill_d;
  logic                 skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0]    skid_data_q, skid_data_d;
  logic                 skid_ill_q, skid_ill_d;
  logic [ILL_CNT_W-1:0] ill_cnt_q, ill_cnt_d;

  logic accept;
  logic drain;

  ext_pipe_core #(
    .IMM_W (IMM_W),
    .DATA_W(DATA_W)
  ) u_core (
    .imm       (imm),
    .ext_op    (ext_op),
    .ext_out   (core_out),
    .illegal_op(core_ill)
  );

  // Ready depends only on stored state, never on out_ready.
  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready;
  assign drain    = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_ill_d   = main_ill_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_ill_d   = skid_ill_q;
    ill_cnt_d    = ill_cnt_q;

    if (drain) begin
      if (skid_valid_q) begin
        // in_ready is low here, so no new input competes for main.
        main_data_d  = skid_data_q;
        main_ill_d   = skid_ill_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_data_d = core_out;
        main_ill_d  = core_ill;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (main_valid_q) begin
        skid_valid_d = 1'b1;
        skid_data_d  = core_out;
        skid_ill_d   = core_ill;
      end else begin
        main_valid_d = 1'b1;
        main_data_d  = core_out;
        main_ill_d   = core_ill;
      end
    end

    if (accept && core_ill && (ill_cnt_q != {ILL_CNT_W{1'b1}})) begin
      ill_cnt_d = ill_cnt_q + ILL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_ill_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_ill_q   <= 1'b0;
      ill_cnt_q    <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_ill_q   <= main_ill_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_ill_q   <= skid_ill_d;
      ill_cnt_q    <= ill_cnt_d;
    end
  end

  assign out_valid  = main_valid_q;
  assign ext_out    = main_data_q;
  assign illegal_op = main_ill_q;
  assign ill_cnt    = ill_cnt_q;

endmodule

// File: tb/tb_ext_pipe.sv
// Bench for ext_pipe: two instances (32-bit/8-bit counter and 64-bit/2-bit counter) share
// stimulus and are checked every cycle against a queue-based reference model.
module tb_ext_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] imm = '0;
  logic [2:0]  ext_op = '0;
  logic        out_ready = 1'b0;

  logic        in_ready_a, out_valid_a, illegal_a;
  logic [31:0] ext_out_a;
  logic [7:0]  ill_cnt_a;
  logic        in_ready_b, out_valid_b, illegal_b;
  logic [63:0] ext_out_b;
  logic [1:0]  ill_cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ext_pipe #(.IMM_W(16), .DATA_W(32), .ILL_CNT_W(8)) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_a),
    .imm       (imm),
    .ext_op    (ext_op),
    .out_valid (out_valid_a),
    .out_ready (out_ready),
    .ext_out   (ext_out_a),
    .illegal_op(illegal_a),
    .ill_cnt   (ill_cnt_a)
  );

  ext_pipe #(.IMM_W(16), .DATA_W(64), .ILL_CNT_W(2)) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_b),
    .imm       (imm),
    .ext_op    (ext_op),
    .out_valid (out_valid_b),
    .out_ready (out_ready),
    .ext_out   (ext_out_b),
    .illegal_op(illegal_b),
    .ill_cnt   (ill_cnt_b)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference extension computed arithmetically for a word of w bits.
  function automatic logic [63:0] ref_ext(input logic [15:0] v, input logic [2:0] op, input int w);
    longint     s;
    logic [63:0] mask;
    s    = longint'($signed(v));
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    case (int'(op))
      0:       return {48'd0, v};
      1:       return 64'(s) & mask;
      2:       return ({48'd0, v} << (w - 16)) & mask;
      3:       return 64'(s * 4) & mask;
      default: return v[15] ? mask : 64'd0;
    endcase
  endfunction

  typedef struct {
    logic [63:0] d32;
    logic [63:0] d64;
    bit          ill;
  } ent_t;

  ent_t q[$];
  int   ill_total = 0;

  always @(negedge rst_n) begin
    q.delete();
    ill_total = 0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      bit   acc;
      ent_t e;
      acc = in_valid && (q.size() < 2);
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (acc) begin
        e.d32 = ref_ext(imm, ext_op, 32);
        e.d64 = ref_ext(imm, ext_op, 64);
        e.ill = (ext_op > 3'd3);
        q.push_back(e);
        if (e.ill) ill_total++;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready_a", 64'(in_ready_a), 64'(q.size() < 2));
      chk("in_ready_b", 64'(in_ready_b), 64'(q.size() < 2));
      chk("out_valid_a", 64'(out_valid_a), 64'(q.size() > 0));
      chk("out_valid_b", 64'(out_valid_b), 64'(q.size() > 0));
      chk("ill_cnt_a", 64'(ill_cnt_a), 64'((ill_total > 255) ? 255 : ill_total));
      chk("ill_cnt_b", 64'(ill_cnt_b), 64'((ill_total > 3) ? 3 : ill_total));
      if (q.size() > 0) begin
        chk("ext_out_a", 64'(ext_out_a), q[0].d32);
        chk("ext_out_b", ext_out_b, q[0].d64);
        chk("illegal_a", 64'(illegal_a), 64'(q[0].ill));
        chk("illegal_b", 64'(illegal_b), 64'(q[0].ill));
      end
    end
  end

  task automatic step(input logic [15:0] v, input logic [2:0] op);
    in_valid = 1'b1;
    imm      = v;
    ext_op   = op;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid_a), 64'd0);
    chk("rst_in_ready", 64'(in_ready_a), 64'd1);
    chk("rst_ill_cnt", 64'(ill_cnt_a), 64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    chk("init_out_valid", 64'(out_valid_a), 64'd0);
    chk("init_ext_out", 64'(ext_out_a), 64'd0);
    chk("init_illegal", 64'(illegal_a), 64'd0);
    chk("init_ill_cnt", 64'(ill_cnt_a), 64'd0);
    chk("init_in_ready", 64'(in_ready_a), 64'd1);
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back modes, latency one.
    out_ready = 1'b1;
    step(16'h8001, 3'b000); chk("t1_zero", 64'(ext_out_a), 64'h0000_8001);
    step(16'h8001, 3'b001); chk("t1_sign", 64'(ext_out_a), 64'hFFFF_8001);
    step(16'h8001, 3'b010); chk("t1_lui", 64'(ext_out_a), 64'h8001_0000);
    step(16'h8001, 3'b011); chk("t1_broff", 64'(ext_out_a), 64'hFFFE_0004);
    chk("t1_valid", 64'(out_valid_a), 64'd1);
    step(16'h7FFF, 3'b001); chk("t2_sign_pos", 64'(ext_out_a), 64'h0000_7FFF);
    step(16'h8000, 3'b101); chk("t2_illegal", 64'(ext_out_a), 64'hFFFF_FFFF);
    chk("t2_illflag", 64'(illegal_a), 64'd1);
    chk("t2_ill_cnt", 64'(ill_cnt_a), 64'd1);
    step(16'hFFFE, 3'b001); chk("t6_sign64", ext_out_b, 64'hFFFF_FFFF_FFFF_FFFE);
    step(16'hFFFE, 3'b010); chk("t6_lui64", ext_out_b, 64'hFFFE_0000_0000_0000);
    idle(2);

    // Stall: two held, third refused until the skid empties.
    out_ready = 1'b0;
    step(16'h0011, 3'b000);
    step(16'h0022, 3'b000);
    chk("t3_full", 64'(in_ready_a), 64'd0);
    step(16'h0033, 3'b000);
    chk("t3_head", 64'(ext_out_a), 64'h11);
    out_ready = 1'b1;
    step(16'h0033, 3'b000); chk("t3_second", 64'(ext_out_a), 64'h22);
    step(16'h0033, 3'b000); chk("t3_third", 64'(ext_out_a), 64'h33);
    idle(2);

    // Saturation of the narrow counter.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(16'h1234, 3'b111);
      chk("t4_cnt2", 64'(ill_cnt_b), 64'((i + 1 > 3) ? 3 : i + 1));
      chk("t4_cnt8", 64'(ill_cnt_a), 64'(i + 1));
    end
    idle(2);

    // Reset while two entries are held.
    out_ready = 1'b0;
    step(16'h1111, 3'b000);
    step(16'h8000, 3'b110);
    chk("t5_held", 64'(out_valid_a), 64'd1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_valid_drop", 64'(out_valid_a), 64'd0);
    chk("t5_cnt_clear", 64'(ill_cnt_a), 64'd0);
    chk("t5_ready", 64'(in_ready_a), 64'd1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    step(16'h00AB, 3'b001); chk("t5_after", 64'(ext_out_a), 64'h0000_00AB);
    idle(1);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      imm       = 16'($urandom);
      ext_op    = 3'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
